bip_debug_unit: RTL and testbench
=================================

BIP_DEBUG_UNIT -- requirements
Module: bip_debug_unit

Interface
REQ-001 The block SHALL have parameter NB_INSTRUC, default 16, instruction width.
REQ-002 The block SHALL have parameter NB_OPCODE, default 5, opcode field width (instruction MSBs).
REQ-003 The block SHALL have parameter NB_ADDR, default 11, program address width.
REQ-004 The block SHALL have parameter NB_DATA, default 16, accumulator and cycle counter width.
REQ-005 The block SHALL have parameter NB_BYTE, default 8, UART byte width.
REQ-006 The block SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port i_rst, input, 1, synchronous active-low reset (0 = reset asserted).
REQ-008 The block SHALL have port i_instruc, input, NB_INSTRUC, instruction currently presented to the CPU.
REQ-009 The block SHALL have port i_addr_program_mem, input, NB_ADDR, CPU program counter.
REQ-010 The block SHALL have port i_acc, input, NB_DATA, CPU accumulator value.
REQ-011 The block SHALL have port i_rx_data, input, NB_BYTE, command byte from the UART receiver.
REQ-012 The block SHALL have port i_rx_valid, input, 1, one-cycle strobe qualifying i_rx_data.
REQ-013 The block SHALL have port i_tx_ready, input, 1, UART transmitter can accept a byte.
REQ-014 The block SHALL have port o_cpu_enable, output, 1, CPU clock enable.
REQ-015 The block SHALL have port o_tx_data, output, NB_BYTE, report byte to the UART transmitter.
REQ-016 The block SHALL have port o_tx_valid, output, 1, o_tx_data is valid.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, STEP, SEND and DONE.
REQ-018 In IDLE, a byte 0x52 ('R') with i_rx_valid=1 SHALL move the FSM to RUN, and 0x53 ('S') SHALL move it to STEP; other bytes SHALL be ignored.
REQ-019 Command bytes received in any state other than IDLE SHALL be ignored.
REQ-020 o_cpu_enable SHALL be 1 exactly in RUN and STEP, as a registered output asserted the cycle after the command.
REQ-021 STEP SHALL last exactly one cycle, then go to SEND.
REQ-022 In RUN, when o_cpu_enable=1 and i_instruc[NB_INSTRUC-1 -: NB_OPCODE]==0 (HALT), the FSM SHALL go to SEND on the next edge with o_cpu_enable=0.
REQ-023 The cycle counter SHALL increment on every cycle o_cpu_enable=1, including the HALT cycle.
REQ-024 The cycle counter SHALL saturate at 0xFFFF and SHALL be cleared only by reset.
REQ-025 On leaving RUN or STEP, the block SHALL capture a snapshot of i_addr_program_mem, i_acc, i_instruc and the post-increment counter value.
REQ-026 SEND SHALL emit an 8-byte frame, MSB-first per field, in this order: PC_hi, PC_lo, ACC_hi, ACC_lo, CNT_hi, CNT_lo, INS_hi, INS_lo.
REQ-027 PC SHALL be zero-extended to 16 bits for framing.
REQ-028 Handshake: o_tx_data SHALL remain stable while o_tx_valid=1 until a rising edge with i_tx_ready=1; the next byte SHALL then present in the following cycle.
REQ-029 o_tx_valid SHALL be asserted continuously across all 8 bytes when i_tx_ready is held at 1, giving 1 byte per cycle.
REQ-030 After the 8th byte is accepted, o_tx_valid SHALL be 0 the next cycle.
REQ-031 After the 8th byte, the FSM SHALL go to DONE if the frame was halt-triggered, or to IDLE if step-triggered.
REQ-032 DONE SHALL hold o_cpu_enable=0 and o_tx_valid=0 and SHALL be exited only by reset.
REQ-033 When i_rx_valid and the HALT condition coincide in RUN, the HALT SHALL take effect and the byte SHALL be dropped.

Reset
REQ-034 While i_rst=0 at a rising edge, the FSM SHALL go to IDLE, and o_cpu_enable, o_tx_valid, o_tx_data, the counter, the snapshot and the byte index SHALL all be cleared to 0.
REQ-035 A reset during SEND SHALL abort the frame, with no further bytes emitted.

Structure
REQ-036 Package bip_debug_pkg SHALL hold the state enum, OPC_HALT=5'b00000, CMD_RUN=8'h52, CMD_STEP=8'h53 and FRAME_BYTES=8.
REQ-037 The byte serializer (snapshot mux, byte index, valid/ready) SHALL be sub-module debug_frame_tx.

Verification
REQ-038 The bench SHALL check: reset then idle, with no command -> o_cpu_enable=0 and o_tx_valid=0 for 20 cycles.
REQ-039 The bench SHALL check: 'R', then i_instruc=16'h081D for 4 cycles, then 16'h001D with PC=11'h005 and ACC=16'h1234, ready=1 -> 5 enable cycles and frame 00 05 12 34 00 05 00 1D in 8 consecutive cycles, then DONE.
REQ-040 The bench SHALL check: 'S' with PC=11'h7FF and instruction 16'h1000 -> 1 enable cycle, frame 07 FF .. 00 01 10 00, FSM back in IDLE.
REQ-041 The bench SHALL check: i_tx_ready toggling 1-0-0-1 during the frame -> each byte held stable until accepted, bytes in order with none lost or duplicated.
REQ-042 The bench SHALL check: 'R' with no HALT for 70000 cycles, then HALT -> CNT bytes FF FF.
REQ-043 The bench SHALL check: i_rst=0 after the 3rd byte is accepted -> o_tx_valid=0 next cycle, and a following 'S' yields a fresh frame with CNT=00 01.

Source files
------------

// File: rtl/bip_debug_pkg.sv
// Shared definitions for the BIP debug unit.
//   state_e     : debug FSM states
//   OPC_HALT    : opcode value that stops a free run
//   CMD_RUN/STEP: UART command bytes accepted in IDLE
//   FRAME_BYTES : length of the snapshot report frame
package bip_debug_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    SEND,
    DONE
  } state_e;

  localparam logic [4:0]  OPC_HALT    = 5'b00000;
  localparam logic [7:0]  CMD_RUN     = 8'h52;
  localparam logic [7:0]  CMD_STEP    = 8'h53;
  localparam int unsigned FRAME_BYTES = 8;

endpackage

// File: rtl/debug_frame_tx.sv
// Snapshot frame serializer for the BIP debug unit.
// Captures a FRAME_BYTES-byte snapshot on i_load and presents it MSB byte
// first on a valid/ready byte interface.
//   i_clk, i_rst   : clock, synchronous active-low reset
//   i_load         : capture i_frame and start a new frame
//   i_frame        : packed snapshot, first byte to send in the MSBs
//   i_tx_ready     : transmitter accepts o_tx_data at this edge
//   o_tx_data      : current byte (registered)
//   o_tx_valid     : o_tx_data is valid (registered)
//   o_done         : last byte is being accepted at this edge
module debug_frame_tx
  import bip_debug_pkg::*;
#(
  parameter int unsigned NB_BYTE = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_load,
  input  logic [FRAME_BYTES*NB_BYTE-1:0] i_frame,
  input  logic                           i_tx_ready,
  output logic [NB_BYTE-1:0]             o_tx_data,
  output logic                           o_tx_valid,
  output logic                           o_done
);

  localparam int unsigned NB_FRAME = FRAME_BYTES * NB_BYTE;
  localparam int unsigned NB_IDX   = $clog2(FRAME_BYTES);

  // The snapshot is held in a shift register: the byte on the wire is
  // always the top byte, so the output mux collapses to a fixed slice.
  logic [NB_FRAME-1:0] frame_q, frame_d;
  logic [NB_IDX-1:0]   idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                accept;

  always_comb begin
    frame_d = frame_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    accept  = valid_q && i_tx_ready;
    o_done  = accept && (idx_q == NB_IDX'(FRAME_BYTES - 1));
    if (i_load) begin
      frame_d = i_frame;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (accept) begin
      if (o_done) begin
        valid_d = 1'b0;
        idx_d   = '0;
      end else begin
        frame_d = frame_q << NB_BYTE;
        idx_d   = idx_q + NB_IDX'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      frame_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      frame_q <= frame_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign o_tx_data  = frame_q[NB_FRAME-1 -: NB_BYTE];
  assign o_tx_valid = valid_q;

endmodule

// File: rtl/bip_debug_unit.sv
// UART-driven debug controller for the BIP CPU.
// 'R' free-runs the CPU until a HALT opcode, 'S' single-steps one cycle.
// Either way a snapshot (PC, ACC, cycle count, instruction) is reported as
// an 8-byte frame. After a halt-triggered frame the unit parks in DONE
// until reset; after a step it returns to IDLE.
//   i_clk, i_rst        : clock, synchronous active-low reset
//   i_instruc           : instruction presented to the CPU
//   i_addr_program_mem  : CPU program counter
//   i_acc               : CPU accumulator
//   i_rx_data/i_rx_valid: command byte from UART receiver
//   i_tx_ready          : UART transmitter accepts a byte
//   o_cpu_enable        : CPU clock enable (registered)
//   o_tx_data/o_tx_valid: report byte to UART transmitter
module bip_debug_unit
  import bip_debug_pkg::*;
#(
  parameter int unsigned NB_INSTRUC = 16,
  parameter int unsigned NB_OPCODE  = 5,
  parameter int unsigned NB_ADDR    = 11,
  parameter int unsigned NB_DATA    = 16,
  parameter int unsigned NB_BYTE    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NB_INSTRUC-1:0] i_instruc,
  input  logic [NB_ADDR-1:0]    i_addr_program_mem,
  input  logic [NB_DATA-1:0]    i_acc,
  input  logic [NB_BYTE-1:0]    i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_cpu_enable,
  output logic [NB_BYTE-1:0]    o_tx_data,
  output logic                  o_tx_valid
);

  localparam int unsigned NB_FIELD = 2 * NB_BYTE;

  state_e               state_q, state_d;
  logic                 cpu_en_q, cpu_en_d;
  logic [NB_DATA-1:0]   cnt_q, cnt_d;
  logic                 halt_frame_q, halt_frame_d;
  logic                 load;
  logic                 tx_done;
  logic                 is_halt;
  logic [FRAME_BYTES*NB_BYTE-1:0] frame;

  assign is_halt = (i_instruc[NB_INSTRUC-1 -: NB_OPCODE] == NB_OPCODE'(OPC_HALT));

  always_comb begin
    state_d      = state_q;
    halt_frame_d = halt_frame_q;
    load         = 1'b0;
    cnt_d        = cnt_q;
    if (cpu_en_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + NB_DATA'(1);
    end
    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == NB_BYTE'(CMD_RUN)) begin
            state_d = RUN;
          end else if (i_rx_data == NB_BYTE'(CMD_STEP)) begin
            state_d = STEP;
          end
        end
      end
      RUN: begin
        if (cpu_en_q && is_halt) begin
          state_d      = SEND;
          load         = 1'b1;
          halt_frame_d = 1'b1;
        end
      end
      STEP: begin
        state_d      = SEND;
        load         = 1'b1;
        halt_frame_d = 1'b0;
      end
      SEND: begin
        if (tx_done) begin
          state_d = halt_frame_q ? DONE : IDLE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    cpu_en_d = (state_d == RUN) || (state_d == STEP);
  end

  // Snapshot uses cnt_d so the reported count includes the final enabled cycle.
  assign frame = {NB_FIELD'(i_addr_program_mem), NB_FIELD'(i_acc),
                  NB_FIELD'(cnt_d), NB_FIELD'(i_instruc)};

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      cpu_en_q     <= 1'b0;
      cnt_q        <= '0;
      halt_frame_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpu_en_q     <= cpu_en_d;
      cnt_q        <= cnt_d;
      halt_frame_q <= halt_frame_d;
    end
  end

  debug_frame_tx #(
    .NB_BYTE(NB_BYTE)
  ) u_frame_tx (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (load),
    .i_frame   (frame),
    .i_tx_ready(i_tx_ready),
    .o_tx_data (o_tx_data),
    .o_tx_valid(o_tx_valid),
    .o_done    (tx_done)
  );

  assign o_cpu_enable = cpu_en_q;

endmodule

// File: tb/tb_bip_debug_unit.sv
// Self-checking bench for bip_debug_unit: table of run/step scenarios with
// a byte scoreboard, plus hand-written reset and abort sequences.
module tb_bip_debug_unit;
  import bip_debug_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ins;
  logic [10:0] pc;
  logic [15:0] acc;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_ready;
  logic        o_cpu_enable;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;

  bip_debug_unit #(
    .NB_INSTRUC(16),
    .NB_OPCODE (5),
    .NB_ADDR   (11),
    .NB_DATA   (16),
    .NB_BYTE   (8)
  ) u_dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_instruc         (ins),
    .i_addr_program_mem(pc),
    .i_acc             (acc),
    .i_rx_data         (rx_data),
    .i_rx_valid        (rx_valid),
    .i_tx_ready        (tx_ready),
    .o_cpu_enable      (o_cpu_enable),
    .o_tx_data         (o_tx_data),
    .o_tx_valid        (o_tx_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    int unsigned n_run;
    logic [10:0] pc;
    logic [15:0] acc;
    logic [15:0] ins_run;
    logic [15:0] ins_last;
    logic [3:0]  ready_pat;
    logic        rx_at_halt;
    int unsigned exp_en;
    logic [15:0] exp_cnt;
    logic        exp_idle;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  exp_q[$];
  int unsigned en_cnt   = 0;
  int unsigned v_cycles = 0;
  int unsigned n_pops   = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_rst   = 1'b0;
  logic [7:0]  prev_data  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle. Samples outputs 1 time unit after the previous edge,
  // with this cycle's inputs already applied.
  task automatic tick();
    logic [7:0] e;
    if (prev_rst && prev_valid && !prev_ready) begin
      chk("hold_valid", 32'(o_tx_valid), 32'd1);
      chk("hold_data", 32'(o_tx_data), 32'(prev_data));
    end
    if (rst && o_tx_valid && tx_ready) begin
      n_pops++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte: got %0h expected no byte", o_tx_data);
      end else begin
        e = exp_q.pop_front();
        if (o_tx_data !== e) begin
          n_fail++;
          $display("FAIL frame_byte: got %0h expected %0h", o_tx_data, e);
        end
      end
    end
    prev_valid = o_tx_valid;
    prev_ready = tx_ready;
    prev_rst   = rst;
    prev_data  = o_tx_data;
    if (o_cpu_enable) en_cnt++;
    if (o_tx_valid) v_cycles++;
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [10:0] p, input logic [15:0] a,
                            input logic [15:0] c, input logic [15:0] i);
    logic [15:0] pe;
    pe = {5'b0, p};
    exp_q.push_back(pe[15:8]); exp_q.push_back(pe[7:0]);
    exp_q.push_back(a[15:8]);  exp_q.push_back(a[7:0]);
    exp_q.push_back(c[15:8]);  exp_q.push_back(c[7:0]);
    exp_q.push_back(i[15:8]);  exp_q.push_back(i[7:0]);
  endtask

  task automatic do_reset();
    rst = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input bit with_reset);
    int unsigned k;
    int          b;
    if (with_reset) do_reset();
    pc  = v.pc;
    acc = v.acc;
    ins = (v.n_run > 0) ? v.ins_run : v.ins_last;
    tx_ready = v.ready_pat[3];
    push_frame(v.pc, v.acc, v.exp_cnt, v.ins_last);
    // A non-command byte in IDLE is ignored.
    rx_data = 8'h41; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    chk("junk_ignored", 32'(o_cpu_enable), 32'd0);
    rx_data = v.cmd; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    chk("cmd_enable", 32'(o_cpu_enable), 32'd1);
    en_cnt = 0;
    v_cycles = 0;
    for (int unsigned i = 0; i < v.n_run; i++) tick();
    ins = v.ins_last;
    if (v.cmd == CMD_RUN) begin
      if (v.rx_at_halt) begin rx_data = CMD_STEP; rx_valid = 1'b1; end
      tick();
      rx_valid = 1'b0;
    end
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      b = 3 - int'(k % 4);
      tx_ready = v.ready_pat[b];
      tick();
      k++;
    end
    if (exp_q.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL frame_timeout: got %0d bytes missing expected 0", exp_q.size());
      exp_q.delete();
    end
    chk("valid_after_frame", 32'(o_tx_valid), 32'd0);
    chk("enable_cycles", en_cnt, v.exp_en);
    if (v.ready_pat == 4'b1111) chk("frame_cycles", v_cycles, 32'd8);
    if (v.exp_idle) begin
      tx_ready = 1'b0;
      rx_data = CMD_STEP; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
      chk("idle_after_step", 32'(o_cpu_enable), 32'd1);
      rst = 1'b0; tick(); tick(); rst = 1'b1;
    end else begin
      tx_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
        rx_valid = (i < 2);
        rx_data  = (i == 0) ? CMD_RUN : CMD_STEP;
        tick();
        chk("done_enable", 32'(o_cpu_enable), 32'd0);
        chk("done_valid", 32'(o_tx_valid), 32'd0);
      end
      rx_valid = 1'b0;
    end
  endtask

  vec_t vecs[5];

  initial begin
    vec_t va;
    int unsigned base;
    int unsigned k;

    vecs[0] = '{CMD_RUN,  4,     11'h005, 16'h1234, 16'h081D, 16'h001D, 4'b1111, 1'b0, 5,     16'h0005, 1'b0};
    vecs[1] = '{CMD_STEP, 0,     11'h7FF, 16'hA5C3, 16'h0000, 16'h1000, 4'b1111, 1'b0, 1,     16'h0001, 1'b1};
    vecs[2] = '{CMD_STEP, 0,     11'h123, 16'h8001, 16'h0000, 16'h0042, 4'b1001, 1'b0, 1,     16'h0001, 1'b1};
    vecs[3] = '{CMD_RUN,  0,     11'h000, 16'h0000, 16'h0000, 16'h07FF, 4'b1001, 1'b1, 1,     16'h0001, 1'b0};
    vecs[4] = '{CMD_RUN,  70000, 11'h3AB, 16'hFFFF, 16'hF81D, 16'h0000, 4'b1111, 1'b0, 70001, 16'hFFFF, 1'b0};

    rst = 1'b0; ins = '0; pc = '0; acc = '0;
    rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;

    // Reset state, then 20 idle cycles with no command.
    tick(); tick();
    chk("rst_enable", 32'(o_cpu_enable), 32'd0);
    chk("rst_valid", 32'(o_tx_valid), 32'd0);
    chk("rst_data", 32'(o_tx_data), 32'd0);
    rst = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_enable", 32'(o_cpu_enable), 32'd0);
      chk("idle_valid", 32'(o_tx_valid), 32'd0);
    end

    for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b1);

    // Reset after the 3rd byte is accepted aborts the frame.
    do_reset();
    pc = 11'h2AA; acc = 16'h5A5A; ins = 16'h3C00; tx_ready = 1'b1;
    push_frame(11'h2AA, 16'h5A5A, 16'h0001, 16'h3C00);
    rx_data = CMD_STEP; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    base = n_pops;
    k = 0;
    while (n_pops < base + 3 && k < 50) begin tick(); k++; end
    chk("abort_pops", n_pops - base, 32'd3);
    rst = 1'b0; tx_ready = 1'b0;
    tick();
    chk("abort_valid", 32'(o_tx_valid), 32'd0);
    exp_q.delete();
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_quiet", 32'(o_tx_valid), 32'd0);
    end
    rst = 1'b1;
    tick();
    va = '{CMD_STEP, 0, 11'h155, 16'hC0DE, 16'h0000, 16'h2001, 4'b1111, 1'b0, 1, 16'h0001, 1'b1};
    run_vec(va, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
